// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, run-length debounce FSM and optional
// auto-repeat for one mechanical push-button; every output is registered.
//
// state              | meaning
// ST_RELEASED        | accepted released, waiting for a synchronised high
// ST_CONFIRM_PRESS   | counting consecutive highs before accepting a press
// ST_PRESSED         | accepted pressed, repeat timer running
// ST_CONFIRM_RELEASE | counting consecutive lows before accepting a release
module btn_debounce #(
  parameter int STABLE_CYCLES = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_CONFIRM_PRESS,
    ST_PRESSED,
    ST_CONFIRM_RELEASE
  } state_t;

  logic              sync1_q, sync2_q;
  state_t            state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= ST_RELEASED;
      stab_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          state_d    = ST_CONFIRM_PRESS;
          stab_cnt_d = STAB_ONE;
        end
      end
      ST_CONFIRM_PRESS: begin
        if (!sync2_q) begin
          state_d    = ST_RELEASED;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = ST_PRESSED;
          stab_cnt_d = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d    = ST_CONFIRM_RELEASE;
          stab_cnt_d = STAB_ONE;
        end
      end
      ST_CONFIRM_RELEASE: begin
        if (sync2_q) begin
          state_d    = ST_PRESSED;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = ST_RELEASED;
          stab_cnt_d = '0;
          level_d    = 1'b0;
          release_d  = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_RELEASED;
        stab_cnt_d = '0;
      end
    endcase
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int REP_W   = $clog2(REP_MAX + 1);
      localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
      localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);

      logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
      logic             phase_q, phase_d;
      logic             repeat_d;
      logic             rep_tick;
      logic             rep_hit;

      // The edge that returns from a release glitch also counts, so a glitch
      // of g cycles delays the next repeat by exactly g.
      always_comb begin
        rep_cnt_d = rep_cnt_q;
        phase_d   = phase_q;
        repeat_d  = 1'b0;
        rep_tick  = sync2_q && ((state_q == ST_PRESSED) || (state_q == ST_CONFIRM_RELEASE));
        rep_hit   = (rep_cnt_q == (phase_q ? REPEAT_LAST : HOLD_LAST));
        if (press_d) begin
          rep_cnt_d = '0;
          phase_d   = 1'b0;
        end else if (rep_tick) begin
          if (rep_hit) begin
            rep_cnt_d = '0;
            phase_d   = 1'b1;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt_q <= '0;
          phase_q   <= 1'b0;
          repeat_q  <= 1'b0;
        end else begin
          rep_cnt_q <= rep_cnt_d;
          phase_q   <= phase_d;
          repeat_q  <= repeat_d;
        end
      end
    end else begin : g_no_repeat
      assign repeat_q = 1'b0;
    end
  endgenerate

  always_comb begin
    btn_level   = level_q;
    btn_press   = press_q;
    btn_release = release_q;
    btn_repeat  = repeat_q;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and synchronises one mechanical push-button input and turns each confirmed press into single-cycle event pulses. It sits directly upstream of the press counter / 7-segment display path in TOP. It consumes the raw, bouncing board button (btnU) and replaces any direct edge detection on the raw pin. Optional auto-repeat lets a held button step the counter repeatedly.

## Interface
- STABLE_CYCLES, 50000: consecutive identical synchronised samples required to accept a level change (1 ms at 50 MHz); must be >= 2.
- HOLD_CYCLES, 25000000: cycles the button must stay accepted-pressed before the first repeat pulse (0.5 s).
- REPEAT_CYCLES, 5000000: cycles between subsequent repeat pulses (0.1 s).
- REPEAT_EN, 0: 1 enables btn_repeat; 0 ties btn_repeat low and the repeat counter is not built.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- btn_in  input  1  raw asynchronous button level, 1 = pressed.
- btn_level  output  1  debounced registered button level.
- btn_press  output  1  one-cycle pulse on each accepted press.
- btn_release  output  1  one-cycle pulse on each accepted release.
- btn_repeat  output  1  one-cycle auto-repeat pulse while held (REPEAT_EN=1).

## Operation
- Synchroniser: two flops, s1 <= btn_in, s2 <= s1. Only s2 feeds the FSM.
- Stability counter: width $clog2(STABLE_CYCLES). Repeat counter: width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
- FSM states:
  - RELEASED: s2=1 -> CONFIRM_PRESS, stab_cnt <= 1.
  - CONFIRM_PRESS: s2=1 with stab_cnt = STABLE_CYCLES-1 -> PRESSED, btn_level <= 1, btn_press <= 1, rep_cnt <= 0. Otherwise s2=1 increments stab_cnt. s2=0 -> RELEASED, stab_cnt <= 0.
  - PRESSED: s2=0 -> CONFIRM_RELEASE, stab_cnt <= 1. Otherwise rep_cnt increments.
  - CONFIRM_RELEASE: s2=0 with stab_cnt = STABLE_CYCLES-1 -> RELEASED, btn_level <= 0, btn_release <= 1. Otherwise s2=0 increments stab_cnt. s2=1 -> PRESSED, stab_cnt <= 0; rep_cnt resumes without being cleared.
- Auto-repeat (REPEAT_EN=1), counting only in PRESSED:
  - rep_cnt = HOLD_CYCLES-1 -> btn_repeat <= 1, rep_cnt <= 0, phase flag set.
  - Once the phase flag is set, the terminal count is REPEAT_CYCLES-1.
  - The phase flag clears on entry to PRESSED from CONFIRM_PRESS.
- btn_level changes only on the accept transitions. Bounces shorter than STABLE_CYCLES never reach the outputs.
- At most one of btn_press / btn_release / btn_repeat is high in any cycle. Each pulse is exactly one cycle.

## Timing
- Reset (rst_n low, any time): immediately and asynchronously s1=s2=0, state=RELEASED, all counters 0, btn_level=0, btn_press=0, btn_release=0, btn_repeat=0, repeat phase cleared.
- Reset mid-press: after rst_n rises with btn_in held high, a fresh full press acceptance follows. Exactly one btn_press; no btn_release is issued for the press that was interrupted.
- Press latency: take edge 0 as the first edge that samples btn_in=1, with btn_in steady afterwards. btn_press and btn_level=1 are visible after edge STABLE_CYCLES+1.
- Release latency: measured the same way from the first edge sampling btn_in=0. btn_release and btn_level=0 are visible after edge STABLE_CYCLES+1.
- Press-to-repeat timing:
  - First btn_repeat: HOLD_CYCLES cycles after btn_press, when no release glitches occur.
  - Subsequent pulses: every REPEAT_CYCLES cycles.
- A glitch of length g < STABLE_CYCLES inside PRESSED delays the next repeat by g cycles. It produces no btn_release.
- No combinational path exists from btn_in to any output.

## Test plan
Run with STABLE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, 20 ns clock.
- Clean press: btn_in 0->1 held 40 cycles. Required: btn_press a single pulse after edge 5 with btn_level=1 from then on. Release clean: btn_release a single pulse after edge 5 of release with btn_level=0.
- Bounce: on press, btn_in toggles 1,0,1,1,0,1 (one cycle each) then holds high. Required: exactly one btn_press, 5 cycles after the final rising edge; release bounce mirrored gives exactly one btn_release.
- Short glitch: 3-cycle high pulse from idle. Required: no btn_press and btn_level stays 0. While held, a 3-cycle low glitch: no btn_release.
- Auto-repeat with REPEAT_EN=1: hold 60 cycles past btn_press. Required: btn_repeat at +20, +28, +36, +44, +52; none after the release is accepted. With REPEAT_EN=0, btn_repeat stays 0 throughout.
- Reset mid-operation: assert rst_n low during CONFIRM_PRESS and again during PRESSED. Required: all outputs are 0 immediately; after release of rst_n with btn_in still high, one btn_press occurs after edge 5.
- Regression on bench stimulus: 15 bouncy presses at the bench timing. Required: exactly 15 btn_press and 15 btn_release pulses.
